// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input-side control.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } router_state_t;

  localparam logic [1:0] ADDR_P0 = 2'd0;
  localparam logic [1:0] ADDR_P1 = 2'd1;
  localparam logic [1:0] ADDR_P2 = 2'd2;

  localparam int WDOG_LIMIT = 63;

  // Picks one of the three per-port flags; address 3 selects nothing.
  function automatic logic sel_port(input logic [1:0] addr, input logic p0,
                                    input logic p1, input logic p2);
    case (addr)
      ADDR_P0: sel_port = p0;
      ADDR_P1: sel_port = p1;
      ADDR_P2: sel_port = p2;
      default: sel_port = 1'b0;
    endcase
  endfunction

  function automatic logic is_stall(input router_state_t s);
    is_stall = (s == FIFO_FULL_STATE) || (s == WAIT_TILL_EMPTY);
  endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Control/status bundle between the router FSM and its neighbouring blocks.
// Handshake: the source holds pkt_valid/din while busy=1; a byte is accepted on a
// posedge where busy=0, and FIFO writes happen only on edges with write_enb_reg=1.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] din;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       detect_addr;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;
  logic       wdog_drop;

  modport slave (
    input  pkt_valid, din, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    output detect_addr, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy, wdog_drop
  );

  modport master (
    output pkt_valid, din, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    input  detect_addr, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy, wdog_drop
  );
endinterface

// File: rtl/router_wdog_ctr.sv
// Stall watchdog: counts consecutive stall cycles and flags the terminal count.
module router_wdog_ctr #(
  parameter int LIMIT = router_pkg::WDOG_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic kill,
  output logic hit,
  output logic drop
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] cnt;

  // A soft reset on the same cycle outranks the watchdog, so no abort is flagged.
  assign hit = stall && (cnt == LIMIT_W) && !kill;

  always_ff @(posedge clk) begin
    if (rst || !stall || hit) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop <= 1'b0;
    else     drop <= hit;
  end
endmodule

// File: rtl/router_fsm.sv
// Router input-side packet sequencer; ROUTER_FSM_WDOG_EN adds a stall watchdog
// that aborts long FIFO_FULL_STATE / WAIT_TILL_EMPTY stalls.
module router_fsm
  import router_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  router_fsm_if.slave   bus,
  output router_state_t dbg_state
);
  router_state_t state, state_nxt;
  logic [1:0]    addr_q;
  logic          sr_sel;
  logic          wdog_hit;

  assign sr_sel = sel_port(addr_q, bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2);

`ifdef ROUTER_FSM_WDOG_EN
  router_wdog_ctr #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .stall (is_stall(state)),
    .kill  (sr_sel),
    .hit   (wdog_hit),
    .drop  (bus.wdog_drop)
  );
`else
  assign wdog_hit      = 1'b0;
  assign bus.wdog_drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DECODE_ADDRESS;
      addr_q <= ADDR_P0;
    end else begin
      state <= state_nxt;
      if (state == DECODE_ADDRESS && bus.pkt_valid) addr_q <= bus.din;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid && bus.din != 2'd3) begin
          if (sel_port(bus.din, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2))
            state_nxt = LOAD_FIRST_DATA;
          else
            state_nxt = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
        else                        state_nxt = LOAD_DATA;
      end
      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (bus.fifo_full) state_nxt = FIFO_FULL_STATE;
        else               state_nxt = DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (sel_port(addr_q, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2))
          state_nxt = LOAD_FIRST_DATA;
      end
      default: state_nxt = DECODE_ADDRESS;
    endcase
    // Later assignments win: soft reset of the active port outranks the watchdog.
    if (wdog_hit) state_nxt = DECODE_ADDRESS;
    if (sr_sel)   state_nxt = DECODE_ADDRESS;
  end

  assign bus.detect_addr   = (state == DECODE_ADDRESS);
  assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state == LOAD_DATA);
  assign bus.full_state    = (state == FIFO_FULL_STATE);
  assign bus.laf_state     = (state == LOAD_AFTER_FULL);
  assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                             (state == LOAD_AFTER_FULL);
  assign bus.busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

  assign dbg_state = state;
endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed vector table, corner sequences, random vs model.
module tb_router_fsm;
  import router_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_fsm_if  bus();
  router_state_t dbg_state;

  router_fsm dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

  // Output vector: {detect, lfd, ld, laf, full, rst_int, wen, busy, wdog_drop}
  localparam logic [8:0] O_DA  = 9'b100000000;
  localparam logic [8:0] O_LFD = 9'b010000010;
  localparam logic [8:0] O_LD  = 9'b001000100;
  localparam logic [8:0] O_LAF = 9'b000100110;
  localparam logic [8:0] O_FFS = 9'b000010010;
  localparam logic [8:0] O_CPE = 9'b000001010;
  localparam logic [8:0] O_LP  = 9'b000000110;
  localparam logic [8:0] O_WTE = 9'b000000010;

  typedef struct {
    logic       r;
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic       pd;
    logic       lpv;
    logic [2:0] emp;
    logic [2:0] sr;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: phase names as plain integers, rules straight from the packet protocol.
  localparam int P_DA = 0, P_LFD = 1, P_LD = 2, P_FFS = 3, P_LAF = 4, P_LP = 5, P_CPE = 6, P_WTE = 7;
  int   m_ph   = P_DA;
  int   m_addr = 0;
  int   m_stall = 0;
  logic m_drop = 1'b0;

  function automatic vec_t mk(input logic r, input logic pv, input logic [1:0] din,
                              input logic ff, input logic pd, input logic lpv,
                              input logic [2:0] emp, input logic [2:0] sr,
                              input logic [8:0] exp);
    vec_t v;
    v.r = r; v.pv = pv; v.din = din; v.ff = ff; v.pd = pd; v.lpv = lpv;
    v.emp = emp; v.sr = sr; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] dut_outs();
    return {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
            bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.wdog_drop};
  endfunction

  function automatic logic [8:0] phase_outs(input int ph);
    case (ph)
      P_DA:    return O_DA;
      P_LFD:   return O_LFD;
      P_LD:    return O_LD;
      P_FFS:   return O_FFS;
      P_LAF:   return O_LAF;
      P_LP:    return O_LP;
      P_CPE:   return O_CPE;
      default: return O_WTE;
    endcase
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst               = v.r;
    bus.pkt_valid     = v.pv;
    bus.din           = v.din;
    bus.fifo_full     = v.ff;
    bus.parity_done   = v.pd;
    bus.low_pkt_valid = v.lpv;
    bus.fifo_empty_0  = v.emp[0];
    bus.fifo_empty_1  = v.emp[1];
    bus.fifo_empty_2  = v.emp[2];
    bus.soft_reset_0  = v.sr[0];
    bus.soft_reset_1  = v.sr[1];
    bus.soft_reset_2  = v.sr[2];
  endtask

  task automatic tick(input vec_t v);
    apply(v);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input vec_t v);
    tick(v);
    check(name, dut_outs(), v.exp);
  endtask

  task automatic model_step(input vec_t v);
    logic stalled, abort, srh, emp_sel;
    int   nxt;
    if (v.r) begin
      m_ph = P_DA; m_addr = 0; m_stall = 0; m_drop = 1'b0;
      return;
    end
    stalled = (m_ph == P_FFS) || (m_ph == P_WTE);
    srh     = (m_addr < 3) ? v.sr[m_addr] : 1'b0;
    abort   = 1'b0;
`ifdef ROUTER_FSM_WDOG_EN
    abort   = stalled && (m_stall == WDOG_LIMIT) && !srh;
`endif
    nxt = m_ph;
    case (m_ph)
      P_DA: if (v.pv && v.din != 2'd3) nxt = v.emp[v.din] ? P_LFD : P_WTE;
      P_LFD: nxt = P_LD;
      P_LD:  nxt = v.ff ? P_FFS : (!v.pv ? P_LP : P_LD);
      P_FFS: nxt = v.ff ? P_FFS : P_LAF;
      P_LAF: nxt = v.pd ? P_DA : (v.lpv ? P_LP : P_LD);
      P_LP:  nxt = P_CPE;
      P_CPE: nxt = v.ff ? P_FFS : P_DA;
      default: begin
        emp_sel = v.emp[m_addr];
        nxt = emp_sel ? P_LFD : P_WTE;
      end
    endcase
    if (srh || abort) nxt = P_DA;
    if (m_ph == P_DA && v.pv) m_addr = int'(v.din);
    m_stall = (stalled && !abort && !srh) ? m_stall + 1 : 0;
    m_drop  = abort;
    m_ph    = nxt;
  endtask

  initial begin
    vec_t v;
    int   n_ffs;

    // rst, then a 3-byte packet to port 1
    tbl.push_back(mk(1,0,0,0,0,0,3'b111,3'b000,O_DA));
    tbl.push_back(mk(1,0,0,0,0,0,3'b111,3'b000,O_DA));
    tbl.push_back(mk(0,1,1,0,0,0,3'b111,3'b000,O_LFD));
    tbl.push_back(mk(0,1,1,0,0,0,3'b111,3'b000,O_LD));
    tbl.push_back(mk(0,1,1,0,0,0,3'b111,3'b000,O_LD));
    tbl.push_back(mk(0,1,1,0,0,0,3'b111,3'b000,O_LD));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_LP));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_CPE));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_DA));
    // full for 4 cycles, then low_pkt_valid takes LAF to parity
    tbl.push_back(mk(0,1,0,0,0,0,3'b111,3'b000,O_LFD));
    tbl.push_back(mk(0,1,0,0,0,0,3'b111,3'b000,O_LD));
    tbl.push_back(mk(0,1,0,1,0,0,3'b111,3'b000,O_FFS));
    tbl.push_back(mk(0,1,0,1,0,0,3'b111,3'b000,O_FFS));
    tbl.push_back(mk(0,1,0,1,0,0,3'b111,3'b000,O_FFS));
    tbl.push_back(mk(0,1,0,1,0,0,3'b111,3'b000,O_FFS));
    tbl.push_back(mk(0,0,0,0,0,1,3'b111,3'b000,O_LAF));
    tbl.push_back(mk(0,0,0,0,0,1,3'b111,3'b000,O_LP));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_CPE));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_DA));
    // fifo_full beats !pkt_valid in LD; parity_done ends LAF
    tbl.push_back(mk(0,1,2,0,0,0,3'b111,3'b000,O_LFD));
    tbl.push_back(mk(0,0,2,0,0,0,3'b111,3'b000,O_LD));
    tbl.push_back(mk(0,0,2,1,0,0,3'b111,3'b000,O_FFS));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_LAF));
    tbl.push_back(mk(0,0,0,0,1,0,3'b111,3'b000,O_DA));
    // din=3 is ignored
    tbl.push_back(mk(0,1,3,0,0,0,3'b111,3'b000,O_DA));
    // CPE with full goes to FFS; LAF with no flags returns to LD
    tbl.push_back(mk(0,1,0,0,0,0,3'b111,3'b000,O_LFD));
    tbl.push_back(mk(0,1,0,0,0,0,3'b111,3'b000,O_LD));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_LP));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_CPE));
    tbl.push_back(mk(0,0,0,1,0,0,3'b111,3'b000,O_FFS));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_LAF));
    tbl.push_back(mk(0,1,0,0,0,0,3'b111,3'b000,O_LD));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_LP));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_CPE));
    tbl.push_back(mk(0,0,0,0,0,0,3'b111,3'b000,O_DA));
    // soft reset: wrong port ignored, own port aborts
    tbl.push_back(mk(0,1,0,0,0,0,3'b111,3'b000,O_LFD));
    tbl.push_back(mk(0,1,0,0,0,0,3'b111,3'b000,O_LD));
    tbl.push_back(mk(0,1,0,0,0,0,3'b111,3'b010,O_LD));
    tbl.push_back(mk(0,1,0,0,0,0,3'b111,3'b001,O_DA));
    // rst mid-packet
    tbl.push_back(mk(0,1,2,0,0,0,3'b011,3'b000,O_WTE));
    tbl.push_back(mk(1,0,0,0,0,0,3'b011,3'b000,O_DA));

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
      if (i == 1) check("reset_state", {6'b0, dbg_state}, {6'b0, DECODE_ADDRESS});
    end

    // WAIT_TILL_EMPTY held 5 cycles, then header load; soft reset of port 2 mid-payload
    step("wte_enter", mk(0,1,2,0,0,0,3'b011,3'b000,O_WTE));
    for (int i = 0; i < 4; i++) step($sformatf("wte_hold%0d", i), mk(0,0,0,0,0,0,3'b011,3'b000,O_WTE));
    step("wte_exit", mk(0,1,0,0,0,0,3'b111,3'b000,O_LFD));
    step("wte_ld",   mk(0,1,0,0,0,0,3'b111,3'b000,O_LD));
    step("sr2_abort", mk(0,1,0,0,0,0,3'b111,3'b100,O_DA));

    // long stall in FIFO_FULL_STATE
    step("stall_lfd", mk(0,1,0,0,0,0,3'b111,3'b000,O_LFD));
    step("stall_ld",  mk(0,1,0,0,0,0,3'b111,3'b000,O_LD));
    step("stall_ffs", mk(0,1,0,1,0,0,3'b111,3'b000,O_FFS));
`ifdef ROUTER_FSM_WDOG_EN
    n_ffs = 1;
    for (int i = 0; i < 200; i++) begin
      tick(mk(0,1,0,1,0,0,3'b111,3'b000,O_FFS));
      if (dut_outs() == O_FFS) n_ffs++;
      else break;
    end
    check("wdog_stall_cycles", 9'(n_ffs), 9'(WDOG_LIMIT + 1));
    check("wdog_abort", dut_outs(), O_DA | 9'b1);
    step("wdog_pulse_end", mk(0,0,0,1,0,0,3'b111,3'b000,O_DA));
`else
    n_ffs = 0;
    for (int i = 0; i < 100; i++) begin
      tick(mk(0,1,0,1,0,0,3'b111,3'b000,O_FFS));
      if (dut_outs() === O_FFS) n_ffs++;
    end
    check("stall_forever", 9'(n_ffs), 9'd100);
`endif

    // random traffic against the model
    v = mk(1,0,0,0,0,0,3'b111,3'b000,O_DA);
    model_step(v);
    tick(v);
    for (int i = 0; i < 2000; i++) begin
      v.r   = ($urandom_range(0, 63) == 0);
      v.pv  = ($urandom_range(0, 3) != 0);
      v.din = 2'($urandom_range(0, 3));
      v.ff  = ($urandom_range(0, 3) == 0);
      v.pd  = ($urandom_range(0, 3) == 0);
      v.lpv = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 3; b++) begin
        v.emp[b] = ($urandom_range(0, 3) != 0);
        v.sr[b]  = ($urandom_range(0, 31) == 0);
      end
      model_step(v);
      v.exp = phase_outs(m_ph) | {8'b0, m_drop};
      step($sformatf("rand%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/router_fsm.md
# router_fsm

Control state machine for the 1x3 router input side. Sequences each incoming packet (address decode, header load, payload load, full stall, parity load and check) and drives the write-enable, detect-address and load-phase strobes consumed by the synchronizer, register and FIFO blocks. Tracks per-port soft reset and destination-FIFO occupancy so that a packet is never started into a non-empty FIFO.

## Interface
- WDOG_LIMIT, 63: stall cycles in FIFO_FULL_STATE / WAIT_TILL_EMPTY before watchdog abort (only with macro)
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- pkt_valid  in  1  packet byte valid from source
- din  in  2  address field (header bits [1:0])
- parity_done  in  1  register block has stored parity byte
- low_pkt_valid  in  1  register block: pkt_valid fell while FIFO full
- fifo_full  in  1  full flag of selected FIFO (from synchronizer)
- fifo_empty_0/1/2  in  1 each  per-FIFO empty flags
- soft_reset_0/1/2  in  1 each  per-port soft reset (from synchronizer)
- detect_addr  out  1  address capture strobe
- lfd_state  out  1  load-first-data (header) phase
- ld_state  out  1  payload load phase
- laf_state  out  1  load-after-full phase
- full_state  out  1  stalled on full FIFO
- rst_int_reg  out  1  parity-check phase, clears internal parity registers
- write_enb_reg  out  1  FIFO write permission
- busy  out  1  source must hold data
- wdog_drop  out  1  one-cycle abort pulse (tied 0 without macro)

## Operation
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- addr_q (2 bits): loaded from din when state==DECODE_ADDRESS and pkt_valid; reset 2'b00.
- DECODE_ADDRESS: pkt_valid and din=N (N in 0..2): fifo_empty_N → LOAD_FIRST_DATA; else → WAIT_TILL_EMPTY. din=3 or !pkt_valid → stay.
- LOAD_FIRST_DATA → LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full → FIFO_FULL_STATE; else !pkt_valid → LOAD_PARITY; else stay.
- FIFO_FULL_STATE: !fifo_full → LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL: parity_done → DECODE_ADDRESS; else low_pkt_valid → LOAD_PARITY; else → LOAD_DATA.
- LOAD_PARITY → CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full → FIFO_FULL_STATE; else → DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty_[addr_q] → LOAD_FIRST_DATA; else stay.
- Priority: rst > soft_reset_[addr_q] (any state → DECODE_ADDRESS) > watchdog > normal transitions. addr_q=3 never occurs outside DECODE_ADDRESS.
- Moore outputs from state: detect_addr=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; full_state=FIFO_FULL_STATE; laf_state=LOAD_AFTER_FULL; rst_int_reg=CHECK_PARITY_ERROR; write_enb_reg=LOAD_DATA|LOAD_PARITY|LOAD_AFTER_FULL; busy=1 in all states except DECODE_ADDRESS and LOAD_DATA.

## Timing
- Reset: state=DECODE_ADDRESS, addr_q=0, watchdog count=0; outputs detect_addr=1, all others 0.
- Transition condition sampled at posedge; outputs update same edge (decoded from state register), i.e. one cycle after the condition is presented.
- Minimum packet (1 payload byte, no full): DECODE_ADDRESS→LFD→LD→LP→CPE→DECODE_ADDRESS, 4 cycles busy-or-load after header.
- Soft reset and rst mid-packet: abort takes effect next edge; no partial state retained besides addr_q (rst clears it, soft reset does not).
- Simultaneous fifo_full and !pkt_valid in LOAD_DATA: fifo_full wins.

## Configuration
- ROUTER_FSM_WDOG_EN defined: 6-bit counter increments each cycle in FIFO_FULL_STATE or WAIT_TILL_EMPTY, clears on any other state; when count==WDOG_LIMIT, next state DECODE_ADDRESS, wdog_drop=1 for exactly that one cycle (registered), counter cleared.
- Undefined: no counter, wdog_drop constant 0, stall states wait indefinitely.

## Structure
- Shared package router_pkg: state enum typedef (router_state_t), address constants ADDR_P0/P1/P2, WDOG_LIMIT default.
- Sub-module router_wdog_ctr (counter + terminal pulse), instantiated only under ROUTER_FSM_WDOG_EN.

## Test plan
- rst=1 two cycles, release → detect_addr=1, busy=0, all other outputs 0, state DECODE_ADDRESS.
- pkt_valid=1, din=1, fifo_empty_1=1, 3 payload bytes, pkt_valid drops → states DA,LFD,LD×3,LP,CPE,DA; write_enb_reg high in LD/LP only.
- din=2, fifo_empty_2=0 for 5 cycles then 1 → WAIT_TILL_EMPTY 5 cycles with busy=1, then LFD.
- fifo_full=1 in LD for 4 cycles, then 0, parity_done=0, low_pkt_valid=1 → FFS×4, LAF, LP, CPE.
- soft_reset_0=1 during LD with addr_q=0 → DECODE_ADDRESS next edge; soft_reset_1 with addr_q=0 → no effect.
- With ROUTER_FSM_WDOG_EN, fifo_full held 1 in FFS → abort to DA after 63 stall cycles, wdog_drop=1 for one cycle.
